// File: rtl/uart_rx.sv
// UART receiver: 8N1, LSB first, mid-bit sampling with start-glitch rejection,
// stop-bit check, and a has_data/data_read handshake with overrun reporting.
module uart_rx #(
   parameter int unsigned CLKS_PER_BIT = 87
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       incoming_bit,
   input  logic       data_read,
   output logic [7:0] data_received,
   output logic       has_data,
   output logic       is_receiving,
   output logic       framing_error,
   output logic       overrun
);

   localparam int unsigned CW = 16;
   localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START_BIT = 3'd1,
      DATA_BITS = 3'd2,
      STOP_BIT  = 3'd3,
      WAIT_HIGH = 3'd4
   } state_t;

   state_t          state, state_n;
   logic            sync1, line;
   logic [CW-1:0]   counter, counter_n;
   logic [2:0]      bit_index, bit_index_n;
   logic [7:0]      shift, shift_n;
   logic [7:0]      data_n;
   logic            has_data_n, receiving_n, framing_n, overrun_n;

   // Two-flop synchronizer; idles high so reset never looks like a start bit
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1 <= 1'b1;
         line  <= 1'b1;
      end else begin
         sync1 <= incoming_bit;
         line  <= sync1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         counter       <= '0;
         bit_index     <= '0;
         shift         <= '0;
         data_received <= '0;
         has_data      <= 1'b0;
         is_receiving  <= 1'b0;
         framing_error <= 1'b0;
         overrun       <= 1'b0;
      end else begin
         state         <= state_n;
         counter       <= counter_n;
         bit_index     <= bit_index_n;
         shift         <= shift_n;
         data_received <= data_n;
         has_data      <= has_data_n;
         is_receiving  <= receiving_n;
         framing_error <= framing_n;
         overrun       <= overrun_n;
      end
   end

   always_comb begin
      state_n     = state;
      counter_n   = counter;
      bit_index_n = bit_index;
      shift_n     = shift;
      data_n      = data_received;
      has_data_n  = has_data;
      framing_n   = 1'b0;
      overrun_n   = 1'b0;

      if (data_read && has_data) has_data_n = 1'b0;

      case (state)
         IDLE: begin
            counter_n   = '0;
            bit_index_n = '0;
            if (!line) state_n = START_BIT;
         end
         START_BIT: begin
            if (counter == HALF) begin
               counter_n = '0;
               state_n   = line ? IDLE : DATA_BITS;
            end else begin
               counter_n = counter + CW'(1);
            end
         end
         DATA_BITS: begin
            if (counter == LAST) begin
               counter_n          = '0;
               shift_n[bit_index] = line;
               if (bit_index == 3'd7) state_n = STOP_BIT;
               else                   bit_index_n = bit_index + 3'd1;
            end else begin
               counter_n = counter + CW'(1);
            end
         end
         STOP_BIT: begin
            if (counter == LAST) begin
               counter_n = '0;
               if (line) begin
                  // A coincident data_read consumes the old byte, so no overrun
                  data_n     = shift;
                  has_data_n = 1'b1;
                  overrun_n  = has_data && !data_read;
                  state_n    = IDLE;
               end else begin
                  framing_n = 1'b1;
                  state_n   = WAIT_HIGH;
               end
            end else begin
               counter_n = counter + CW'(1);
            end
         end
         WAIT_HIGH: begin
            counter_n = '0;
            if (line) state_n = IDLE;
         end
         default: begin
            state_n     = IDLE;
            counter_n   = '0;
            bit_index_n = '0;
         end
      endcase

      receiving_n = (state_n == START_BIT) || (state_n == DATA_BITS) ||
                    (state_n == STOP_BIT);
   end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial-to-parallel UART receiver: 8 data bits, LSB first, one start bit, one stop bit, no parity, at the same CLKS_PER_BIT framing as the UART transmitter it pairs with. It synchronizes the incoming line, rejects start-bit glitches, samples each bit at mid-period, and checks the stop bit. It holds each received byte behind a has_data/data_read handshake, with framing-error and overrun reporting. It sits between the FPGA RX pin and the command/sensor-protocol logic.

## Interface
- CLKS_PER_BIT, 87: clock cycles per UART bit (clock freq / baud); legal range 4..65535.
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- incoming_bit  in  1  raw serial line from the pin (asynchronous, idle high).
- data_read  in  1  consumer acknowledge; a 1-cycle pulse clears has_data.
- data_received  out  8  last valid byte; changes only on a valid stop bit.
- has_data  out  1  level, high while an unread valid byte is held.
- is_receiving  out  1  high in START_BIT, DATA_BITS and STOP_BIT.
- framing_error  out  1  1-cycle pulse when the stop bit is sampled low.
- overrun  out  1  1-cycle pulse when a valid byte overwrites an unread byte.

## Operation
- Synchronizer: 2 flops on incoming_bit, both reset to 1. The FSM sees only the second flop (line).
- HALF = (CLKS_PER_BIT-1)/2, integer division. The bit counter is 16 bits.
- IDLE: counter=0, bit index=0. If line==0, go to START_BIT.
- START_BIT: count from 0. When counter==HALF, sample the line:
  - line 0: counter=0, go to DATA_BITS.
  - line 1: glitch, go to IDLE with no outputs changed.
- DATA_BITS: when counter==CLKS_PER_BIT-1, shift the line into shift[bit index] and reset counter to 0. After bit 7, go to STOP_BIT; otherwise increment the bit index.
- STOP_BIT: when counter==CLKS_PER_BIT-1, sample the line:
  - line 1: data_received<=shift, has_data<=1. overrun pulses if has_data was already 1 and data_read is 0 that cycle. Go to IDLE, which allows back-to-back frames.
  - line 0: framing_error pulses. data_received and has_data are unchanged. Go to WAIT_HIGH.
- WAIT_HIGH: remain until line==1, then go to IDLE. A held-low line (break) never produces a spurious frame.
- has_data handshake:
  - data_read while has_data=1 clears it next cycle.
  - data_read while has_data=0 is ignored.
  - data_read in the same cycle as a valid stop leaves has_data=1 with the new byte and no overrun.
- Undefined state encodings go to IDLE.

## Timing
- Reset values: data_received=0x00, has_data=0, is_receiving=0, framing_error=0, overrun=0, both sync flops=1, state=IDLE.
- Reset takes effect immediately (asynchronously). Reset mid-frame abandons the frame; the first start after release is received normally.
- Cycle 0 is the cycle IDLE first observes line==0. Pin-to-line latency is 2 clocks.
- START_BIT is entered in cycle 1; start sample in cycle 1+HALF.
- Data bit k (0..7) is sampled in cycle 1+HALF+(k+1)*CLKS_PER_BIT.
- Stop sample in cycle 1+HALF+9*CLKS_PER_BIT. data_received, has_data and any overrun/framing_error pulse become visible in the following cycle.
- is_receiving goes high in cycle 1 and low the cycle after the stop sample.
- framing_error and overrun are exactly 1 cycle wide and never both high.
- has_data falls in the cycle after a data_read pulse.

## Test plan
- Reset: assert reset mid-idle and mid-frame with line toggling. All outputs must read their reset values while reset is high. After release, 0x5A (CLKS_PER_BIT=16) is received correctly.
- Basic frame, CLKS_PER_BIT=16: drive 0xA5. has_data must rise exactly 153 cycles after start detection with data_received=0xA5 and no error pulses. A data_read pulse clears has_data next cycle.
- Glitch: line low for 4 clocks, then high. is_receiving may pulse, but has_data stays 0, no error pulses, and the FSM returns to IDLE. A following 0x3C frame is received correctly.
- Framing/break: 0x3C with stop bit low, then line held low for 3 bit times, then high. Require:
  - exactly one framing_error pulse;
  - has_data stays 0 and data_received is unchanged;
  - no further frame until a real start; a following 0x81 is received correctly.
- Overrun: back-to-back 0x11 then 0x22 with no data_read. Exactly one overrun pulse at the 0x22 arrival; data_received=0x22, has_data=1. Repeat with data_read coincident with the second stop sample: no overrun pulse.
- Baud margin: CLKS_PER_BIT=87, transmitter running at ±3% bit period, bytes 0x00, 0xFF, 0x55. All are received correctly with no errors.
